pc_sequencer: RTL and testbench

Fetch and program-counter stage of the multi-cycle datapath. It holds the 64-bit PC, the instruction register and the 2-bit control state register, and fetches instructions from instruction memory through a ready handshake. It presents `instruction` and `state` to the per-opcode control units and applies their `Psel`/`PCsel`/`K`/`nextState` outputs at the end of each execute cycle. It also drives the PC-derived value onto the data bus when `EN_PC` is asserted.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 76 +++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch handshake, control-unit word and PC bus signals around pc_sequencer.
// master is the sequencer side; slave is instruction memory plus the control units.
interface pc_sequencer_if;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        mem_ready;
  logic [31:0] mem_instruction;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic        exec_valid;
  logic [1:0]  Psel;
  logic        PCsel;
  logic [63:0] K;
  logic [63:0] in;
  logic [1:0]  nextState;
  logic        EN_PC;
  logic [63:0] pc4;
  logic [63:0] pc_bus;
  logic        pc_bus_en;

  modport master (
    output fetch_req, fetch_addr, instruction, state, exec_valid, pc4, pc_bus, pc_bus_en,
    input  mem_ready, mem_instruction, Psel, PCsel, K, in, nextState, EN_PC
  );

  modport slave (
    input  fetch_req, fetch_addr, instruction, state, exec_valid, pc4, pc_bus, pc_bus_en,
    output mem_ready, mem_instruction, Psel, PCsel, K, in, nextState, EN_PC
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch / program-counter stage: holds PC, IR and control state, fetches through a ready
// handshake and applies the control units' PC update at the end of each execute cycle.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clock,
  input logic           reset_n,
  pc_sequencer_if.master bus
);

  localparam logic [0:0] PhFetch = 1'b0;
  localparam logic [0:0] PhExec  = 1'b1;

  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  state_q, state_d;
  logic [0:0]  phase_q, phase_d;
  logic [63:0] pc_plus4;
  logic [63:0] target;

  assign pc_plus4 = pc_q + 64'd4;
  assign target   = bus.PCsel ? bus.K : bus.in;

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    state_d = state_q;
    phase_d = phase_q;
    if (phase_q == PhFetch) begin
      // mem_ready is only honoured here, so a stray ready during EXEC is ignored
      if (bus.mem_ready) begin
        ir_d    = bus.mem_instruction;
        state_d = 2'b00;
        phase_d = PhExec;
      end
    end else begin
      unique case (bus.Psel)
        2'b00: pc_d = pc_q;
        2'b01: pc_d = pc_plus4;
        2'b10: pc_d = {target[63:2], 2'b00};
        2'b11: pc_d = pc_plus4 + {target[61:0], 2'b00};
      endcase
      state_d = bus.nextState;
      if (bus.nextState == 2'b00) begin
        phase_d = PhFetch;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      state_q <= 2'b00;
      phase_q <= PhFetch;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    bus.fetch_req   = (phase_q == PhFetch);
    bus.exec_valid  = (phase_q == PhExec);
    bus.fetch_addr  = pc_q;
    bus.instruction = ir_q;
    bus.state       = state_q;
    bus.pc4         = pc_plus4;
    bus.pc_bus_en   = bus.EN_PC & (phase_q == PhExec);
    // zero-gated rather than tri-stated so the bus mux can OR sources together
    bus.pc_bus      = bus.pc_bus_en ? pc_plus4 : 64'h0;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written multi-cycle sequences and a
// randomized run, all checked against a behavioural model of the fetch/execute rules.
module tb_pc_sequencer;

  localparam logic [63:0] RstPc = 64'h100;

  logic clock = 1'b0;
  logic reset_n;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RstPc)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  logic [31:0] m_ir;
  logic [1:0]  m_state;
  bit          m_exec;
  bit          m_valid = 1'b0;

  typedef struct {
    logic [63:0] start_pc;
    logic [1:0]  psel;
    logic        pcsel;
    logic [63:0] k;
    logic [63:0] inv;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    logic [63:0] tgt;
    if (m_valid) begin
      chk("pc4", bus.pc4, m_pc + 64'd4);
      chk("pc_bus_en", {63'h0, bus.pc_bus_en}, {63'h0, bus.EN_PC && m_exec});
      chk("pc_bus", bus.pc_bus, (bus.EN_PC && m_exec) ? m_pc + 64'd4 : 64'h0);
    end
    if (!reset_n) begin
      m_pc = RstPc; m_ir = 32'h0; m_state = 2'b00; m_exec = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_exec) begin
        if (bus.mem_ready) begin
          m_ir = bus.mem_instruction; m_state = 2'b00; m_exec = 1'b1;
        end
      end else begin
        tgt = bus.PCsel ? bus.K : bus.in;
        case (bus.Psel)
          2'd1: m_pc = m_pc + 64'd4;
          2'd2: m_pc = (tgt / 4) * 4;
          2'd3: m_pc = m_pc + 64'd4 + tgt * 4;
          default: m_pc = m_pc;
        endcase
        m_state = bus.nextState;
        m_exec  = (bus.nextState != 2'b00);
      end
    end
    @(posedge clock);
    #1;
    if (m_valid) begin
      chk("fetch_req", {63'h0, bus.fetch_req}, {63'h0, !m_exec});
      chk("exec_valid", {63'h0, bus.exec_valid}, {63'h0, m_exec});
      chk("fetch_addr", bus.fetch_addr, m_pc);
      chk("instruction", {32'h0, bus.instruction}, {32'h0, m_ir});
      chk("state", {62'h0, bus.state}, {62'h0, m_state});
    end
  endtask

  task automatic fetch(input logic [31:0] word);
    bus.mem_ready = 1'b1;
    bus.mem_instruction = word;
    cycle();
    bus.mem_ready = 1'b0;
  endtask

  task automatic exec(input logic [1:0] psel, input logic pcsel, input logic [63:0] k,
                      input logic [63:0] inv, input logic [1:0] ns);
    bus.Psel = psel; bus.PCsel = pcsel; bus.K = k; bus.in = inv; bus.nextState = ns;
    cycle();
    bus.Psel = 2'b00; bus.nextState = 2'b00;
  endtask

  task automatic set_pc(input logic [63:0] v);
    fetch(32'h0);
    exec(2'b10, 1'b1, v, 64'h0, 2'b00);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_instruction = 32'h0;
    bus.Psel = 2'b00; bus.PCsel = 1'b0; bus.K = 64'h0; bus.in = 64'h0;
    bus.nextState = 2'b00; bus.EN_PC = 1'b0;

    vecs[0] = '{64'h100, 2'b01, 1'b0, 64'h0, 64'h0, 64'h104};
    vecs[1] = '{64'h100, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'hFC};
    vecs[2] = '{64'h100, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h104};
    vecs[3] = '{64'h100, 2'b10, 1'b0, 64'h0, 64'h2003, 64'h2000};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 2'b01, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[5] = '{64'h200, 2'b11, 1'b0, 64'h0, 64'h1, 64'h208};
    vecs[6] = '{64'h200, 2'b00, 1'b0, 64'h55, 64'h77, 64'h200};
    vecs[7] = '{64'h0, 2'b10, 1'b1, 64'h3007, 64'h0, 64'h3004};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFF0, 2'b11, 1'b1, 64'h4, 64'h0, 64'h4};

    // Reset held two cycles, then three idle fetch cycles
    cycle();
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle fetch_req", {63'h0, bus.fetch_req}, 64'h1);
      chk("idle fetch_addr", bus.fetch_addr, 64'h100);
      chk("idle exec_valid", {63'h0, bus.exec_valid}, 64'h0);
    end
    fetch(32'h5400_0040);
    chk("first instruction", {32'h0, bus.instruction}, 64'h5400_0040);
    chk("first state", {62'h0, bus.state}, 64'h0);
    chk("first exec_valid", {63'h0, bus.exec_valid}, 64'h1);
    exec(2'b00, 1'b0, 64'h0, 64'h0, 2'b00);

    for (int i = 0; i < 9; i++) begin
      set_pc(vecs[i].start_pc);
      fetch(32'h8B00_0000 + i);
      exec(vecs[i].psel, vecs[i].pcsel, vecs[i].k, vecs[i].inv, 2'b00);
      chk($sformatf("table[%0d] pc", i), bus.fetch_addr, vecs[i].exp_pc);
    end

    // Two-cycle instruction; ready during EXEC must not disturb the IR
    set_pc(64'h300);
    fetch(32'hAAAA_0001);
    bus.mem_ready = 1'b1; bus.mem_instruction = 32'hDEAD_BEEF;
    exec(2'b00, 1'b0, 64'h0, 64'h0, 2'b01);
    bus.mem_ready = 1'b0;
    chk("multi ir held", {32'h0, bus.instruction}, 64'hAAAA_0001);
    chk("multi state", {62'h0, bus.state}, 64'h1);
    chk("multi exec", {63'h0, bus.exec_valid}, 64'h1);
    chk("multi pc held", bus.fetch_addr, 64'h300);
    exec(2'b01, 1'b0, 64'h0, 64'h0, 2'b00);
    chk("multi pc final", bus.fetch_addr, 64'h304);
    chk("multi back to fetch", {63'h0, bus.fetch_req}, 64'h1);

    // Reset during the first EXEC cycle of a multi-cycle instruction
    set_pc(64'h500);
    fetch(32'hAAAA_0002);
    reset_n = 1'b0;
    exec(2'b01, 1'b0, 64'h0, 64'h0, 2'b01);
    reset_n = 1'b1;
    chk("midreset pc", bus.fetch_addr, RstPc);
    chk("midreset state", {62'h0, bus.state}, 64'h0);
    chk("midreset fetch_req", {63'h0, bus.fetch_req}, 64'h1);
    chk("midreset ir", {32'h0, bus.instruction}, 64'h0);

    // PC bus gating
    set_pc(64'h40);
    bus.EN_PC = 1'b1;
    #1;
    chk("fetch pc_bus", bus.pc_bus, 64'h0);
    chk("fetch pc_bus_en", {63'h0, bus.pc_bus_en}, 64'h0);
    fetch(32'hAAAA_0003);
    #1;
    chk("exec pc_bus", bus.pc_bus, 64'h44);
    chk("exec pc_bus_en", {63'h0, bus.pc_bus_en}, 64'h1);
    exec(2'b01, 1'b0, 64'h0, 64'h0, 2'b00);
    bus.EN_PC = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      bus.mem_instruction = $urandom;
      bus.Psel = 2'($urandom_range(0, 3));
      bus.PCsel = 1'($urandom_range(0, 1));
      bus.K = {$urandom, $urandom};
      bus.in = {$urandom, $urandom};
      bus.nextState = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.EN_PC = 1'($urandom_range(0, 1));
      #1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
